// File: rtl/fmm_reduce_kernel_mul_pipe.sv
// Pipelined integer multiplier with per-operand signedness and a valid tag per sample.
// Optional running-sum output stage when FMM_MUL_ACC_EN is defined.
module fmm_reduce_kernel_mul_pipe #(
  parameter int DIN0_WIDTH  = 64,
  parameter int DIN1_WIDTH  = 31,
  parameter int DOUT_WIDTH  = 95,
  parameter int NUM_STAGE   = 3,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
`ifdef FMM_MUL_ACC_EN
  input  logic                  acc_clear,
`endif
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  busy
);

  localparam int PW         = DIN0_WIDTH + DIN1_WIDTH;
  localparam bit ANY_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  generate
    if (NUM_STAGE < 2) begin : g_bad_stage
      $error("fmm_reduce_kernel_mul_pipe: NUM_STAGE must be >= 2");
    end
    if (DIN0_WIDTH < 2 || DIN1_WIDTH < 2 || DOUT_WIDTH < 2) begin : g_bad_width
      $error("fmm_reduce_kernel_mul_pipe: widths must be >= 2");
    end
  endgenerate

  logic [DIN0_WIDTH-1:0] a_q;
  logic [DIN1_WIDTH-1:0] b_q;
  logic [NUM_STAGE:1]    vld_q;
  logic [DOUT_WIDTH-1:0] pipe_q [2:NUM_STAGE];
  logic [DOUT_WIDTH-1:0] res;
  logic [PW-1:0]         a_w;
  logic [PW-1:0]         b_w;
  logic [PW-1:0]         prod;
  logic                  a_sb;
  logic                  b_sb;

  // Extending both operands to the product width gives the same low PW bits as a
  // one-bit-extended signed multiply, and the full product always fits in PW bits.
  assign a_sb = (DIN0_SIGNED != 0) && a_q[DIN0_WIDTH-1];
  assign b_sb = (DIN1_SIGNED != 0) && b_q[DIN1_WIDTH-1];
  assign a_w  = {{DIN1_WIDTH{a_sb}}, a_q};
  assign b_w  = {{DIN0_WIDTH{b_sb}}, b_q};
  assign prod = a_w * b_w;

  generate
    if (DOUT_WIDTH <= PW) begin : g_trunc
      assign res = prod[DOUT_WIDTH-1:0];
    end else begin : g_ext
      assign res = {{(DOUT_WIDTH-PW){ANY_SIGNED && prod[PW-1]}}, prod};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= '0;
      for (int i = 2; i <= NUM_STAGE; i++) pipe_q[i] <= '0;
    end else if (ce) begin
      a_q       <= din0;
      b_q       <= din1;
      vld_q     <= {vld_q[NUM_STAGE-1:1], in_valid};
      pipe_q[2] <= res;
      for (int i = 3; i <= NUM_STAGE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign busy = |vld_q;

`ifdef FMM_MUL_ACC_EN
  logic [NUM_STAGE:1]    clr_q;
  logic [DOUT_WIDTH-1:0] acc_q;
  logic                  acc_vld_q;

  // The clear flag rides alongside its sample so it acts on that sample's product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_q     <= '0;
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
    end else if (ce) begin
      clr_q     <= {clr_q[NUM_STAGE-1:1], acc_clear};
      acc_vld_q <= vld_q[NUM_STAGE];
      if (vld_q[NUM_STAGE]) begin
        acc_q <= clr_q[NUM_STAGE] ? pipe_q[NUM_STAGE] : acc_q + pipe_q[NUM_STAGE];
      end
    end
  end

  assign dout      = acc_q;
  assign out_valid = acc_vld_q;
`else
  assign dout      = pipe_q[NUM_STAGE];
  assign out_valid = vld_q[NUM_STAGE];
`endif

endmodule

// File: tb/tb_fmm_reduce_kernel_mul_pipe.sv
// Scoreboard bench: stimulus pushes expected results with their due ce-cycle, monitors pop and compare.
// Covers the default unsigned build, a signed 8x8 pair of instances, and FMM_MUL_ACC_EN when defined.
module tb_fmm_reduce_kernel_mul_pipe;

`ifdef FMM_MUL_ACC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    logic [127:0] d;
    int           due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] din0 = '0;
  logic [30:0] din1 = '0;
  logic        acc_clear = 1'b0;
  logic        out_valid;
  logic [94:0] dout;
  logic        busy;

  logic        s_valid = 1'b0;
  logic [7:0]  s_a = '0;
  logic [7:0]  s_b = '0;
  logic        ov16, ov8, busy16, busy8;
  logic [15:0] dout16;
  logic [7:0]  dout8;

  exp_t q_main[$];
  exp_t q16[$];
  exp_t q8[$];
  int   ce_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fmm_reduce_kernel_mul_pipe dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1),
`ifdef FMM_MUL_ACC_EN
    .acc_clear(acc_clear),
`endif
    .out_valid(out_valid), .dout(dout), .busy(busy)
  );

  fmm_reduce_kernel_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .NUM_STAGE(3),
                               .DIN0_SIGNED(1), .DIN1_SIGNED(1)) dut16 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(s_valid),
    .din0(s_a), .din1(s_b),
`ifdef FMM_MUL_ACC_EN
    .acc_clear(1'b1),
`endif
    .out_valid(ov16), .dout(dout16), .busy(busy16)
  );

  fmm_reduce_kernel_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(3),
                               .DIN0_SIGNED(1), .DIN1_SIGNED(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(s_valid),
    .din0(s_a), .din1(s_b),
`ifdef FMM_MUL_ACC_EN
    .acc_clear(1'b1),
`endif
    .out_valid(ov8), .dout(dout8), .busy(busy8)
  );

  always @(posedge clk) if (ce) ce_cnt <= ce_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s unexpected output actual=%0h required=none", name, act);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid && ce) begin
      if (q_main.size() == 0) unexpected("main_dout", 128'(dout));
      else begin
        e = q_main.pop_front();
        check("main_dout", 128'(dout), e.d);
        check("main_latency", 128'(ce_cnt), 128'(e.due));
      end
    end
    if (reset_n && ov16 && ce) begin
      if (q16.size() == 0) unexpected("s16_dout", 128'(dout16));
      else begin
        e = q16.pop_front();
        check("s16_dout", 128'(dout16), e.d);
        check("s16_latency", 128'(ce_cnt), 128'(e.due));
      end
    end
    if (reset_n && ov8 && ce) begin
      if (q8.size() == 0) unexpected("s8_dout", 128'(dout8));
      else begin
        e = q8.pop_front();
        check("s8_dout", 128'(dout8), e.d);
      end
    end
  end

  task automatic step(input bit ce_v, input bit v, input logic [63:0] a, input logic [30:0] b,
                      input bit clr, input logic [94:0] exp_d);
    @(posedge clk);
    #1;
    ce = ce_v; in_valid = v; din0 = a; din1 = b; acc_clear = clr; s_valid = 1'b0;
    if (ce_v && v) q_main.push_back('{128'(exp_d), ce_cnt + LAT});
  endtask

  task automatic sstep(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e16,
                       input logic [7:0] e8);
    @(posedge clk);
    #1;
    ce = 1'b1; in_valid = 1'b0; s_valid = 1'b1; s_a = a; s_b = b;
    q16.push_back('{128'(e16), ce_cnt + LAT});
    q8.push_back('{128'(e8), ce_cnt + LAT});
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    step(1, 0, 0, 0, 0, 0);
    while ((q_main.size() + q16.size() + q8.size()) != 0 && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    if ((q_main.size() + q16.size() + q8.size()) != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout pending=%0d required=0", q_main.size() + q16.size() + q8.size());
      q_main.delete(); q16.delete(); q8.delete();
    end
  endtask

  logic [94:0] exp2 [8] = '{95'd0, 95'd2, 95'd6, 95'd12, 95'd20, 95'd30, 95'd42, 95'd56};

  initial begin
    #12;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_dout", 128'(dout), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    #1 reset_n = 1'b1;

    // Test 1: widest unsigned operands, busy profile
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 31'h7FFF_FFFF, 1, 95'h7FFF_FFFE_FFFF_FFFF_8000_0001);
    for (int c = 1; c <= 4; c++) begin
      step(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("busy_cycle%0d", c), 128'(busy), 128'(c <= 3));
    end
    drain();

    // Test 2: streaming with two ce=0 holes
    begin
      int i;
      i = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
        if (cyc == 2 || cyc == 5) step(0, 1, 64'(i), 31'(i + 1), 1, 0);
        else begin
          step(1, 1, 64'(i), 31'(i + 1), 1, exp2[i]);
          i++;
        end
      end
    end
    drain();

    // Test 3: signed 8x8 with 16-bit and 8-bit results
    sstep(8'h80, 8'h80, 16'h4000, 8'h00);
    sstep(8'hFF, 8'h7F, 16'hFF81, 8'h81);
    sstep(8'h80, 8'h7F, 16'hC080, 8'h80);
    drain();

    // Test 4: reset with three samples in flight
    step(1, 1, 64'd3, 31'd5, 1, 95'd15);
    step(1, 1, 64'd4, 31'd5, 1, 95'd20);
    step(1, 1, 64'd5, 31'd5, 1, 95'd25);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_dout", 128'(dout), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    q_main.delete();
    reset_n = 1'b1;
    repeat (6) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 64'd9, 31'd9, 1, 95'd81);
    drain();

`ifdef FMM_MUL_ACC_EN
    // Test 5: running sum with a bubble
    step(1, 1, 64'd2, 31'd3, 1, 95'd6);
    step(1, 1, 64'd4, 31'd5, 0, 95'd26);
    step(1, 0, 64'd9, 31'd9, 0, 0);
    step(1, 1, 64'd1, 31'd1, 0, 95'd27);
    step(1, 1, 64'd7, 31'd1, 1, 95'd7);
    drain();
`endif

    repeat (3) step(1, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog elapsed=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
